// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a start/busy/done handshake and flush/reset abort.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    // Handshake: start is accepted only in IDLE when flush and done are both low.
    // busy is high for every CALC cycle; done pulses for exactly one cycle with
    // result already valid, and result holds until a later op completes.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q;
    logic [2:0]        op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN:0]     rem_q;
    logic              neg_q;
    logic              rem_neg_q;
    logic [XLEN-1:0]   result_q;
    logic              done_q;

    logic              is_div_in;
    logic              a_signed_in;
    logic              b_signed_in;
    logic              sign_a_in;
    logic              sign_b_in;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic              accept;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_sgn;
    logic [XLEN-1:0]   quo_sgn;
    logic [XLEN-1:0]   rem_sgn;
    logic [XLEN-1:0]   fin_value;
    logic              unused_rem_msb;

    // Operand decode for the op being offered in IDLE.
    always_comb begin
        is_div_in   = funct3[2];
        a_signed_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed_in = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                      (funct3 == 3'b110);
        sign_a_in   = a_signed_in & op_a[XLEN-1];
        sign_b_in   = b_signed_in & op_b[XLEN-1];
        // -MIN_NEG wraps to itself, which is still the correct unsigned magnitude.
        mag_a       = sign_a_in ? -op_a : op_a;
        mag_b       = sign_b_in ? -op_b : op_b;
        div_zero    = is_div_in && (op_b == '0);
        div_ovf     = is_div_in && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
        accept      = (state_q == ST_IDLE) && start && !flush && !done_q;
    end

    // One iteration of each algorithm, plus the sign fix-up and output select for FIN.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                    (prod_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        prod_sgn  = neg_q ? -prod_q : prod_q;
        quo_sgn   = neg_q ? -quo_q : quo_q;
        rem_sgn   = rem_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        case (op_q)
            3'b000:                  fin_value = prod_sgn[XLEN-1:0];
            3'b001, 3'b010, 3'b011:  fin_value = prod_sgn[2*XLEN-1:XLEN];
            3'b100, 3'b101:          fin_value = quo_sgn;
            default:                 fin_value = rem_sgn;
        endcase
    end

    // After each restoring step the partial remainder is below the divisor,
    // so its top bit is only meaningful inside the subtract.
    assign unused_rem_msb = rem_q[XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= funct3;
                        cnt_q     <= CNT_W'(XLEN);
                        mcand_q   <= is_div_in ? mag_b : mag_a;
                        prod_q    <= {{XLEN{1'b0}}, mag_b};
                        quo_q     <= mag_a;
                        rem_q     <= '0;
                        neg_q     <= sign_a_in ^ sign_b_in;
                        rem_neg_q <= sign_a_in;
                        if (div_zero) begin
                            quo_q     <= '1;
                            rem_q     <= {1'b0, op_a};
                            neg_q     <= 1'b0;
                            rem_neg_q <= 1'b0;
                            state_q   <= ST_FIN;
                        end else if (div_ovf) begin
                            quo_q     <= op_a;
                            rem_q     <= '0;
                            neg_q     <= 1'b0;
                            rem_neg_q <= 1'b0;
                            state_q   <= ST_FIN;
                        end else begin
                            state_q   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (op_q[2]) begin
                            rem_q <= div_diff[XLEN] ? div_shift : div_diff;
                            quo_q <= {quo_q[XLEN-2:0], ~div_diff[XLEN]};
                        end else begin
                            prod_q <= {mul_sum, prod_q[XLEN-1:1]};
                        end
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    if (!flush) begin
                        result_q <= fin_value;
                        done_q   <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state_q == ST_CALC);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32): a behavioural model fills a scoreboard queue at
// issue time; each test pops and compares result, latency and handshake behaviour.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [XLEN-1:0] exp_q[$];
    int              lat_q[$];
    logic [XLEN-1:0] last_result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] model(input logic [2:0] f, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        sr  = '0;
        case (f)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'b010: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == '0) return '1;
                if (ovf) return a;
                sr = sa / sb;
                return sr;
            end
            3'b101: return (b == '0) ? '1 : a / b;
            3'b110: begin
                if (b == '0) return a;
                if (ovf) return '0;
                sr = sa % sb;
                return sr;
            end
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        if (f[2] && ((b == '0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return XLEN + 1;
    endfunction

    // Called at a negedge; raises start across one posedge (E0) and returns at the
    // following negedge, scrambling the now don't-care operand inputs.
    task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        exp_q.push_back(model(f, a, b));
        lat_q.push_back(model_lat(f, a, b));
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    // Waits for done, reporting k where done is seen in the cycle after edge E(k).
    task automatic wait_done(input int budget, output logic [XLEN-1:0] res, output int lat,
                             output int busy_cyc, output bit seen);
        seen     = 1'b0;
        lat      = -1;
        busy_cyc = 0;
        res      = '0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                seen = 1'b1;
                lat  = k;
                res  = result;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; flush = 1'b0; funct3 = 3'b101; op_a = 32'h55; op_b = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        last_result = '0;
    endtask

    task automatic test_multiply();
        logic [2:0]      fs[4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        logic [XLEN-1:0] as[4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [XLEN-1:0] bs[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [XLEN-1:0] res, e;
        int lat, bc, el;
        bit seen;
        for (int i = 0; i < 4; i++) begin
            issue(fs[i], as[i], bs[i]);
            wait_done(60, res, lat, bc, seen);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            n_cmp++; if (!seen || res !== e) begin n_fail++; $display("FAIL mul_result[%0d]: got %h expected %h (seen=%0d)", i, res, e, seen); end
            n_cmp++; if (lat != el) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, lat, el); end
            n_cmp++; if (bc != XLEN) begin n_fail++; $display("FAIL mul_busy_cycles[%0d]: got %0d expected %0d", i, bc, XLEN); end
            last_result = e;
        end
    endtask

    task automatic test_divide();
        logic [2:0]      fs[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [XLEN-1:0] as[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [XLEN-1:0] bs[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [XLEN-1:0] res, e;
        int lat, bc, el;
        bit seen;
        for (int i = 0; i < 4; i++) begin
            issue(fs[i], as[i], bs[i]);
            wait_done(60, res, lat, bc, seen);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            n_cmp++; if (!seen || res !== e) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h (seen=%0d)", i, res, e, seen); end
            n_cmp++; if (lat != el) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, el); end
            last_result = e;
        end
    endtask

    task automatic test_div_special();
        logic [2:0]      fs[4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [XLEN-1:0] as[4] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
        logic [XLEN-1:0] bs[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [XLEN-1:0] res, e;
        int lat, bc, el;
        bit seen;
        for (int i = 0; i < 4; i++) begin
            issue(fs[i], as[i], bs[i]);
            wait_done(10, res, lat, bc, seen);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            n_cmp++; if (!seen || res !== e) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h (seen=%0d)", i, res, e, seen); end
            n_cmp++; if (lat != el) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d expected %0d", i, lat, el); end
            n_cmp++; if (bc != 0) begin n_fail++; $display("FAIL special_busy[%0d]: got %0d cycles expected 0", i, bc); end
            last_result = e;
        end
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] res, e;
        int lat, bc, el, dones;
        bit seen;
        // Flush in CALC at cycle 10 of a DIV.
        issue(3'b100, 32'd1000, 32'd7);
        void'(exp_q.pop_back()); void'(lat_q.pop_back());
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_calc_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_calc_done: got %b expected 0", done); end
        n_cmp++; if (result !== last_result) begin n_fail++; $display("FAIL flush_calc_result: got %h expected %h", result, last_result); end
        // The very next cycle accepts a new op.
        issue(3'b101, 32'd100, 32'd7);
        wait_done(60, res, lat, bc, seen);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        n_cmp++; if (!seen || res !== e) begin n_fail++; $display("FAIL flush_next_result: got %h expected %h (seen=%0d)", res, e, seen); end
        n_cmp++; if (lat != el) begin n_fail++; $display("FAIL flush_next_latency: got %0d expected %0d", lat, el); end
        last_result = e;
        // Flush in FIN of a divide-by-zero.
        issue(3'b101, 32'h77, 32'd0);
        void'(exp_q.pop_back()); void'(lat_q.pop_back());
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL flush_fin_done: got %0d pulses expected 0", dones); end
        n_cmp++; if (result !== last_result) begin n_fail++; $display("FAIL flush_fin_result: got %h expected %h", result, last_result); end
        // Flush in IDLE blocks a concurrent start.
        start = 1'b1; flush = 1'b1; funct3 = 3'b101; op_a = 32'h99; op_b = '0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL flush_idle_start: got %0d active cycles expected 0", dones); end
    endtask

    task automatic test_busy_start();
        logic [XLEN-1:0] got, e;
        int dones;
        issue(3'b000, 32'h1234, 32'h5678);
        dones = 0;
        got   = '0;
        for (int k = 0; k < 80; k++) begin
            if (done) begin dones++; got = result; end
            if (k == 3 || k == 12 || k == 25 || k == 33) begin
                start = 1'b1; funct3 = 3'b101; op_a = $urandom; op_b = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        e = exp_q.pop_front(); void'(lat_q.pop_front());
        n_cmp++; if (dones != 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d expected 1", dones); end
        n_cmp++; if (got !== e) begin n_fail++; $display("FAIL busy_start_result: got %h expected %h", got, e); end
        n_cmp++; if (result !== e) begin n_fail++; $display("FAIL busy_start_hold: got %h expected %h", result, e); end
        last_result = e;
    endtask

    task automatic test_reset_mid();
        int dones;
        issue(3'b000, 32'hDEAD_BEEF, 32'h0000_1357);
        void'(exp_q.pop_back()); void'(lat_q.pop_back());
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        n_cmp++; if (result !== '0) begin n_fail++; $display("FAIL rst_mid_result: got %h expected 0", result); end
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 50; k++) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", dones); end
        last_result = '0;
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] res, e, a, b;
        logic [2:0] f;
        int lat, bc, el;
        bit seen;
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (i == 5) begin f = 3'b100; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i == 6) begin f = 3'b001; a = 32'h8000_0000; b = 32'h7FFF_FFFF; end
            issue(f, a, b);
            wait_done(60, res, lat, bc, seen);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            n_cmp++; if (!seen || res !== e) begin n_fail++; $display("FAIL b2b_result[%0d] f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, e); end
            n_cmp++; if (lat != el) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, el); end
            last_result = e;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        last_result = '0;
        @(negedge clk);
        test_reset();
        test_multiply();
        test_divide();
        test_div_special();
        test_flush();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
